rr_arb_3ch: RTL and testbench
=============================

Name: rr_arb_3ch

Overview:
- Round-robin arbiter for three requesters; produces the 2-bit select that steers the downstream 3:1 data select mux.
- Selects one channel and holds the grant for a multi-cycle transfer.
- Releases the grant on requester drop, on a `last` beat, or on a hold timeout.
- Sits directly upstream of the mux; `sel` connects straight to the mux select input.

Parameters:
- MAX_HOLD, 16, maximum consecutive BUSY cycles per grant before forced release (legal range 2..255).
- CW, $clog2(MAX_HOLD), hold-counter width (derived; do not override).

Ports:
- clk      input   1    single clock, all state on rising edge
- rst_n    input   1    reset, asynchronous, active-low
- req      input   3    request per channel; bit i = channel i
- last     input   3    final-beat flag per channel; sampled only for the current owner while its req is high
- gnt      output  3    one-hot grant, registered; 000 when idle
- sel      output  2    mux select, registered: ch0=00, ch1=01, ch2=10; never 11
- valid    output  1    high while any grant is held (equals |gnt)
- timeout  output  1    one-cycle pulse, the cycle after a forced release

Behaviour:
- Reset (async assert, sync deassert by the environment):
  - gnt=000, sel=00, valid=0, timeout=0.
  - State IDLE, priority pointer ptr=0 (ch0 highest), hold counter cnt=0.
- States:
  - IDLE: no owner. If req!=000, pick the winner and go to BUSY; otherwise stay in IDLE.
  - BUSY: owner o held. Release when any of the following holds (evaluated every cycle):
    - (a) req[o]=0;
    - (b) req[o]=1 and last[o]=1, meaning this cycle is the final beat;
    - (c) cnt==MAX_HOLD-1, which is a forced release.
- Pick rule: search order ptr, ptr+1, ptr+2 (mod 3); the first asserted req wins.
- Latency: a req seen in IDLE produces gnt/sel/valid at the next rising edge (1 cycle).
- On release of owner o:
  - ptr <= (o+1) mod 3.
  - The pick is re-evaluated in the same cycle against the current req using the new ptr order, so o is lowest priority.
  - If a winner exists: next cycle gnt/sel switch directly to the winner; stay in BUSY; cnt <= 0. There is no bubble cycle.
  - If no winner exists: go to IDLE; gnt=000, valid=0, sel retains its last value.
- cnt:
  - Cleared on every new grant.
  - Incremented each BUSY cycle that does not release.
  - Saturation is never reached because (c) fires first.
- Timeout:
  - timeout=1 for exactly the one cycle after a release caused solely by (c).
  - If (a) or (b) is true in the same cycle, the release is normal and timeout stays 0.
- Simultaneous conditions:
  - (a) and (b) together: treated as a normal release.
  - req rising on a non-owner during BUSY: no effect until release.
- last on a non-owner channel, or while idle: ignored.
- Reset asserted mid-transfer: all outputs go to reset values immediately (async); ptr returns to 0.
- gnt is always zero-hot or one-hot. sel always equals the encoding of the one-hot gnt while valid=1.

Decomposition:
- Package arb_pkg:
  - constant NCH=3;
  - enum state_t {IDLE, BUSY};
  - function idx2sel(idx) returning the 2-bit encoding above.
- Sub-module rr_pick3 (combinational):
  - inputs: req[2:0], ptr[1:0];
  - outputs: win_idx[1:0], win_any.
  - Reused for both the IDLE pick and the release re-pick.
- Top holds the FSM, ptr, cnt and output registers.

Test Plan:
- Reset with req=111: after rst_n rises, next edge gives gnt=001, sel=00, valid=1. Pulse last[0]: next edge gives gnt=010, sel=01 with no idle cycle.
- Single requester: req=100 for 3 cycles, then req=000. Expect gnt=100, sel=10 for 3 cycles, then gnt=000, valid=0, sel stays 10.
- Fairness: req=111 held, last pulsed on each owner's 2nd beat. Grant sequence must be ch0, ch1, ch2, ch0 (sel 00, 01, 10, 00), each holding 2 cycles.
- Timeout with MAX_HOLD=4: req=001 held, last=000, req[1]=1. Expect ch0 granted 4 cycles, then gnt=010 and timeout=1 for one cycle. With req[1]=0 instead, expect ch0 re-granted (sole requester) and cnt reset.
- Timeout coincident with last: MAX_HOLD=4, last[0]=1 on the 4th BUSY cycle. Expect normal release with timeout=0.
- Mid-transfer reset: drop rst_n while gnt=010. Expect gnt=000, sel=00, valid=0 asynchronously. After release with req=110, the first grant goes to ch1 (ptr=0 search order 0,1,2).

Source files
------------

// File: rtl/rr_arb_3ch_pkg.sv
// Shared definitions for the three-channel round-robin arbiter: channel count,
// FSM state type and the channel-index helpers used by the picker and the top.
package arb_pkg;

  localparam int NCH = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Mux select encoding: ch0=00, ch1=01, ch2=10; 11 is never produced.
  function automatic logic [1:0] idx2sel(input logic [1:0] idx);
    case (idx)
      2'd1:    return 2'b01;
      2'd2:    return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] idx2onehot(input logic [1:0] idx);
    case (idx)
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

  // Channel visited k steps after base in the circular search order.
  function automatic logic [1:0] rot_idx(input logic [1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NCH) s = s - NCH;
    return 2'(s);
  endfunction

endpackage

// File: rtl/rr_arb_3ch_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
// req/last are level signals sampled every rising edge; gnt/sel/valid/timeout
// are registered and valid one edge after the request that caused them.
interface rr_arb_3ch_if;
  import arb_pkg::*;

  logic [2:0] req;
  logic [2:0] last;
  logic [2:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic       timeout;
  state_t     state;

  modport master (
    output req, last,
    input  gnt, sel, valid, timeout, state
  );

  modport slave (
    input  req, last,
    output gnt, sel, valid, timeout, state
  );

endinterface

// File: rtl/rr_arb_3ch_pick3.sv
// Combinational round-robin pick: first asserted request in the order
// ptr, ptr+1, ptr+2 (mod 3).
module rr_pick3
  import arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] win_idx,
  output logic       win_any
);

  // Walk the order backwards so the earliest candidate overwrites later ones.
  always_comb begin
    win_idx = 2'd0;
    win_any = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (req[rot_idx(ptr, k)]) begin
        win_any = 1'b1;
        win_idx = rot_idx(ptr, k);
      end
    end
  end

endmodule

// File: rtl/rr_arb_3ch.sv
// Round-robin arbiter for three requesters; holds a grant for a multi-cycle
// transfer and drives the downstream 3:1 mux select directly.
module rr_arb_3ch
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arb_3ch_if.slave   bus
);

  localparam int CW = $clog2(MAX_HOLD);

  state_t        state;
  logic [1:0]    ptr;
  logic [CW-1:0] cnt;
  logic [2:0]    gnt_q;
  logic [1:0]    sel_q;
  logic          timeout_q;

  logic [1:0]    own;
  logic          own_req;
  logic          own_last;
  logic          hold_max;
  logic          release_now;
  logic          forced;
  logic [1:0]    ptr_next;
  logic [1:0]    pick_ptr;
  logic [1:0]    win_idx;
  logic          win_any;

  // sel_q always encodes the current owner while BUSY.
  assign own      = sel_q;
  assign own_req  = (own == 2'd2) ? bus.req[2]  : (own == 2'd1) ? bus.req[1]  : bus.req[0];
  assign own_last = own_req &
                    ((own == 2'd2) ? bus.last[2] : (own == 2'd1) ? bus.last[1] : bus.last[0]);
  assign hold_max = (cnt == CW'(MAX_HOLD - 1));

  assign release_now = (state == BUSY) && (!own_req || own_last || hold_max);
  assign forced      = hold_max && own_req && !own_last;
  assign ptr_next    = (own == 2'd2) ? 2'd0 : own + 2'd1;

  // On release the re-pick already uses the rotated pointer, so the old owner
  // ranks last and the handover needs no idle bubble.
  assign pick_ptr = (state == BUSY) ? ptr_next : ptr;

  rr_pick3 u_pick (
    .req     (bus.req),
    .ptr     (pick_ptr),
    .win_idx (win_idx),
    .win_any (win_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      cnt       <= '0;
      gnt_q     <= 3'b000;
      sel_q     <= 2'b00;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (win_any) begin
            state <= BUSY;
            gnt_q <= idx2onehot(win_idx);
            sel_q <= idx2sel(win_idx);
            cnt   <= '0;
          end
        end
        BUSY: begin
          if (release_now) begin
            ptr       <= ptr_next;
            timeout_q <= forced;
            if (win_any) begin
              gnt_q <= idx2onehot(win_idx);
              sel_q <= idx2sel(win_idx);
              cnt   <= '0;
            end else begin
              state <= IDLE;
              gnt_q <= 3'b000;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.valid   = |gnt_q;
  assign bus.timeout = timeout_q;
  assign bus.state   = state;

endmodule

// File: tb/tb_rr_arb_3ch.sv
// Directed bench for rr_arb_3ch (MAX_HOLD=4): each step queues the expected
// registered outputs and checks them after the following rising edge.
module tb_rr_arb_3ch;
  import arb_pkg::*;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   passed = 0;

  // Packed as {gnt[2:0], sel[1:0], valid, timeout, state}.
  logic [7:0] exp_q[$];

  rr_arb_3ch_if bus ();

  rr_arb_3ch #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] observed();
    return {bus.gnt, bus.sel, bus.valid, bus.timeout, 1'(bus.state)};
  endfunction

  function automatic logic [7:0] expect_vec(input logic [2:0] g, input logic [1:0] s,
                                            input logic to);
    return {g, s, |g, to, |g};
  endfunction

  task automatic compare(input string tag);
    logic [7:0] e;
    logic [7:0] o;
    checks++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s expected queue empty", tag);
    end else begin
      e = exp_q.pop_front();
      o = observed();
      assert (o === e) passed++;
      else $error("FAIL %s observed gnt/sel/v/to/st=%b required=%b", tag, o, e);
    end
  endtask

  task automatic step(input string tag, input logic [2:0] r, input logic [2:0] l,
                      input logic [2:0] g, input logic [1:0] s, input logic to);
    bus.req  = r;
    bus.last = l;
    exp_q.push_back(expect_vec(g, s, to));
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  initial begin
    rst_n    = 1'b0;
    bus.req  = 3'b111;
    bus.last = 3'b000;
    @(negedge clk);
    @(negedge clk);
    exp_q.push_back(expect_vec(3'b000, 2'b00, 1'b0));
    compare("reset");
    rst_n = 1'b1;

    // Reset with all requesting, then last on the first beat hands straight to ch1.
    step("t1_grant0", 3'b111, 3'b000, 3'b001, 2'b00, 1'b0);
    step("t1_switch", 3'b111, 3'b001, 3'b010, 2'b01, 1'b0);

    // Single requester ch2; sel holds after drop.
    step("s2_grant2", 3'b100, 3'b000, 3'b100, 2'b10, 1'b0);
    step("s2_hold1",  3'b100, 3'b000, 3'b100, 2'b10, 1'b0);
    step("s2_hold2",  3'b100, 3'b000, 3'b100, 2'b10, 1'b0);
    step("s2_drop",   3'b000, 3'b000, 3'b000, 2'b10, 1'b0);
    step("s2_idle",   3'b000, 3'b000, 3'b000, 2'b10, 1'b0);

    // Fairness: last on each owner's second beat.
    step("f_ch0a", 3'b111, 3'b000, 3'b001, 2'b00, 1'b0);
    step("f_ch0b", 3'b111, 3'b000, 3'b001, 2'b00, 1'b0);
    step("f_ch1a", 3'b111, 3'b001, 3'b010, 2'b01, 1'b0);
    step("f_ch1b", 3'b111, 3'b000, 3'b010, 2'b01, 1'b0);
    step("f_ch2a", 3'b111, 3'b010, 3'b100, 2'b10, 1'b0);
    step("f_ch2b", 3'b111, 3'b000, 3'b100, 2'b10, 1'b0);
    step("f_ch0c", 3'b111, 3'b100, 3'b001, 2'b00, 1'b0);
    step("f_ch0d", 3'b111, 3'b000, 3'b001, 2'b00, 1'b0);
    step("f_drop", 3'b000, 3'b000, 3'b000, 2'b00, 1'b0);

    // Timeout with a waiting ch1 (ptr is 1 here, so ch0 wins only by being alone).
    step("to_grant0", 3'b001, 3'b000, 3'b001, 2'b00, 1'b0);
    step("to_b",      3'b011, 3'b000, 3'b001, 2'b00, 1'b0);
    step("to_c",      3'b011, 3'b000, 3'b001, 2'b00, 1'b0);
    step("to_d",      3'b011, 3'b000, 3'b001, 2'b00, 1'b0);
    step("to_fire",   3'b011, 3'b000, 3'b010, 2'b01, 1'b1);
    step("to_clear",  3'b001, 3'b000, 3'b001, 2'b00, 1'b0);

    // Timeout as sole requester: re-granted, hold count restarts.
    step("so_b",      3'b001, 3'b000, 3'b001, 2'b00, 1'b0);
    step("so_c",      3'b001, 3'b000, 3'b001, 2'b00, 1'b0);
    step("so_d",      3'b001, 3'b000, 3'b001, 2'b00, 1'b0);
    step("so_fire",   3'b001, 3'b000, 3'b001, 2'b00, 1'b1);
    step("so_b2",     3'b001, 3'b000, 3'b001, 2'b00, 1'b0);
    step("so_c2",     3'b001, 3'b000, 3'b001, 2'b00, 1'b0);
    step("so_d2",     3'b001, 3'b000, 3'b001, 2'b00, 1'b0);
    step("so_fire2",  3'b001, 3'b000, 3'b001, 2'b00, 1'b1);

    // last on a non-owner is ignored; last coincident with the hold limit is normal.
    step("co_b",      3'b001, 3'b000, 3'b001, 2'b00, 1'b0);
    step("co_c_nown", 3'b011, 3'b010, 3'b001, 2'b00, 1'b0);
    step("co_d",      3'b011, 3'b000, 3'b001, 2'b00, 1'b0);
    step("co_last",   3'b011, 3'b001, 3'b010, 2'b01, 1'b0);

    // Asynchronous reset while ch1 owns; pointer must return to 0.
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(expect_vec(3'b000, 2'b00, 1'b0));
    compare("mid_rst");
    bus.req = 3'b110;
    @(negedge clk);
    rst_n = 1'b1;
    step("rst_pick1", 3'b110, 3'b000, 3'b010, 2'b01, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
